// File: rtl/beta_regfile.sv
// ---------------------------------------------------------------------------
// beta_regfile
//
// Purpose:
//   32 x 32-bit register file for the Beta processor. It sits directly in
//   front of the ALU. Port 1 (rd1) supplies operand A. Port 2 (rd2) supplies
//   the B mux and the store-data path. The single write port is fed by the
//   writeback mux.
//   The z flag (rd1 == 0) drives the BEQ/BNE branch decision.
//   R31 reads as zero and is never stored.
//
// Ports:
//   clk     in   1        rising-edge clock
//   rst_n   in   1        asynchronous active-low reset, clears all registers
//   ra      in   AWIDTH   read address for port 1 (instr[20:16])
//   rb      in   AWIDTH   Rb field (instr[15:11])
//   rc      in   AWIDTH   Rc field (instr[25:21])
//   ra2sel  in   1        port-2 address select: 0 = rb, 1 = rc (ST reads Rc)
//   wa      in   AWIDTH   write address (Rc or XP already selected upstream)
//   wd      in   DWIDTH   write data from the writeback mux
//   werf    in   1        write enable
//   rd1     out  DWIDTH   contents of ra
//   rd2     out  DWIDTH   contents of (ra2sel ? rc : rb)
//   z       out  1        1 when rd1 is all zeros
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN - when defined, a write in flight is forwarded to any
//   read port whose address matches it in the same cycle. The pipelined Beta
//   needs this when writeback and register read share a cycle. When the
//   macro is undefined, reads always return the stored contents.
// ---------------------------------------------------------------------------
module beta_regfile #(
    parameter int NREGS  = 32,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] ra,
    input  logic [AWIDTH-1:0] rb,
    input  logic [AWIDTH-1:0] rc,
    input  logic              ra2sel,
    input  logic [AWIDTH-1:0] wa,
    input  logic [DWIDTH-1:0] wd,
    input  logic              werf,
    output logic [DWIDTH-1:0] rd1,
    output logic [DWIDTH-1:0] rd2,
    output logic              z
);

    // The highest index is the architectural zero register.
    localparam logic [AWIDTH-1:0] ZERO_REG = AWIDTH'(NREGS - 1);

    // Only registers 0..NREGS-2 have storage.
    logic [DWIDTH-1:0] regs_q [NREGS-1];
    logic [DWIDTH-1:0] regs_d [NREGS-1];

    logic              write_en;
    logic [AWIDTH-1:0] rd2_addr;
    logic [DWIDTH-1:0] rd1_raw;
    logic [DWIDTH-1:0] rd2_raw;

    // A write is real only when enabled, aimed at a stored register, and
    // reset is not held. Including rst_n here keeps the bypass path quiet
    // during reset, so reads still see zeros. An X on werf makes this
    // condition non-true, so the if below takes the no-write path and the
    // stored state is left alone.
    always_comb begin
        write_en = (werf == 1'b1) && (wa != ZERO_REG) && rst_n;
    end

    // Next-state for the storage array: hold everything, then overlay the
    // single addressed register when a write is accepted.
    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[wa] = wd;
        end
    end

    // Register array. An asynchronous reset clears every stored register.
    // The write itself happens only on a rising edge with reset released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS - 1; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational reads from the stored contents. The zero register is
    // substituted for the array lookup, so index 31 never selects storage.
    always_comb begin
        rd2_addr = ra2sel ? rc : rb;
        rd1_raw  = (ra == ZERO_REG) ? '0 : regs_q[ra];
        rd2_raw  = (rd2_addr == ZERO_REG) ? '0 : regs_q[rd2_addr];
    end

    // Output selection. With bypass enabled, each port forwards wd
    // independently when its address matches the accepted write. z is
    // always taken from the final rd1, so it follows any forwarded value.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        rd1 = (write_en && (wa == ra))       ? wd : rd1_raw;
        rd2 = (write_en && (wa == rd2_addr)) ? wd : rd2_raw;
`else
        rd1 = rd1_raw;
        rd2 = rd2_raw;
`endif
        z = ~|rd1;
    end

endmodule

// File: tb/tb_beta_regfile.sv
// ---------------------------------------------------------------------------
// tb_beta_regfile
//
// Directed testbench for beta_regfile. It keeps a reference model of the 31
// stored registers, updated only by the writes this bench issues. Expected
// read values come from that model or from hand-computed constants. The
// same-cycle hazard expectations depend on whether REGFILE_BYPASS_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_beta_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rc;
    logic        ra2sel;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        werf;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        z;

    logic [31:0] model [31];
    int          error_count;
    int          check_count;

    beta_regfile #(
        .NREGS (32),
        .DWIDTH(32),
        .AWIDTH(5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ra    (ra),
        .rb    (rb),
        .rc    (rc),
        .ra2sel(ra2sel),
        .wa    (wa),
        .wd    (wd),
        .werf  (werf),
        .rd1   (rd1),
        .rd2   (rd2),
        .z     (z)
    );

    // 10 ns clock. Rising edges occur at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point. Every check is counted here, and any
    // mismatch is reported.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive the read-side inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] c, input logic sel);
        ra     = a;
        rb     = b;
        rc     = c;
        ra2sel = sel;
        #1;
    endtask

    // One-cycle write. Inputs are driven just after an edge and removed just
    // after the next edge. The model ignores writes to R31.
    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        wa   = addr;
        wd   = data;
        werf = 1'b1;
        @(posedge clk);
        #1;
        werf = 1'b0;
        if (addr != 5'd31) model[addr] = data;
    endtask

    // Check every address on both ports against the model. rd1 uses ra,
    // and rd2 uses rb with ra2sel = 0.
    task automatic sweepAll(input string tag);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] exp_val;
            exp_val = (i == 31) ? 32'h0 : model[i];
            applyStimulus(5'(i), 5'(i), 5'd0, 1'b0);
            checkOutput($sformatf("%s_rd1_r%0d", tag, i), rd1, exp_val);
            checkOutput($sformatf("%s_rd2_r%0d", tag, i), rd2, exp_val);
        end
    endtask

    initial begin
        error_count = 0;
        check_count = 0;
        for (int i = 0; i < 31; i++) model[i] = 32'h0;
        rst_n  = 1'b0;
        werf   = 1'b0;
        wa     = 5'd0;
        wd     = 32'h0;
        ra     = 5'd0;
        rb     = 5'd0;
        rc     = 5'd0;
        ra2sel = 1'b0;

        // Hold reset for two cycles and sweep addresses 0..30 while it is held.
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 31; i++) begin
            applyStimulus(5'(i), 5'(i), 5'd0, 1'b0);
            checkOutput($sformatf("rst_rd1_r%0d", i), rd1, 32'h0);
            checkOutput($sformatf("rst_rd2_r%0d", i), rd2, 32'h0);
            checkOutput($sformatf("rst_z_r%0d", i), {31'h0, z}, 32'h1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write, then read on both ports.
        writeReg(5'd5, 32'hDEADBEEF);
        writeReg(5'd30, 32'h00000004);
        applyStimulus(5'd5, 5'd30, 5'd0, 1'b0);
        checkOutput("wr_rd1_r5", rd1, 32'hDEADBEEF);
        checkOutput("wr_z_r5", {31'h0, z}, 32'h0);
        checkOutput("wr_rd2_r30", rd2, 32'h00000004);

        // A write to R31 is discarded. R31 reads zero and nothing else changes.
        writeReg(5'd31, 32'hFFFFFFFF);
        applyStimulus(5'd31, 5'd31, 5'd31, 1'b1);
        checkOutput("zr_rd1", rd1, 32'h0);
        checkOutput("zr_z", {31'h0, z}, 32'h1);
        checkOutput("zr_rd2_rc", rd2, 32'h0);
        sweepAll("zr");

        // werf = 0 leaves state unchanged even with an active address and data.
        wa = 5'd5;
        wd = 32'h0BADF00D;
        @(posedge clk);
        #1;
        applyStimulus(5'd5, 5'd0, 5'd0, 1'b0);
        checkOutput("nowe_rd1_r5", rd1, 32'hDEADBEEF);

        // The port-2 address select chooses between rb and rc.
        writeReg(5'd3, 32'h00000011);
        writeReg(5'd7, 32'h00000022);
        applyStimulus(5'd3, 5'd3, 5'd7, 1'b0);
        checkOutput("sel0_rd2", rd2, 32'h00000011);
        applyStimulus(5'd3, 5'd3, 5'd7, 1'b1);
        checkOutput("sel1_rd2", rd2, 32'h00000022);
        checkOutput("sel1_rd1_same", rd1, 32'h00000011);

        // Same-cycle read of a register that is being written.
        writeReg(5'd9, 32'h00000001);
        wa   = 5'd9;
        wd   = 32'h0;
        werf = 1'b1;
        applyStimulus(5'd9, 5'd9, 5'd0, 1'b0);
`ifdef REGFILE_BYPASS_EN
        checkOutput("haz_rd1", rd1, 32'h0);
        checkOutput("haz_z", {31'h0, z}, 32'h1);
        checkOutput("haz_rd2", rd2, 32'h0);
`else
        checkOutput("haz_rd1", rd1, 32'h1);
        checkOutput("haz_z", {31'h0, z}, 32'h0);
        checkOutput("haz_rd2", rd2, 32'h1);
`endif
        @(posedge clk);
        #1;
        werf = 1'b0;
        model[9] = 32'h0;
        #1;
        checkOutput("haz_post_rd1", rd1, 32'h0);
        checkOutput("haz_post_z", {31'h0, z}, 32'h1);
        sweepAll("pre_rst");

        // Assert reset between edges while a write to R12 is pending.
        writeReg(5'd12, 32'hA5A5A5A5);
        applyStimulus(5'd12, 5'd5, 5'd0, 1'b0);
        wa   = 5'd12;
        wd   = 32'h12345678;
        werf = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_rd1_now", rd1, 32'h0);
        checkOutput("arst_z_now", {31'h0, z}, 32'h1);
        checkOutput("arst_rd2_now", rd2, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("arst_rd1_held", rd1, 32'h0);
        werf = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("arst_rd1_rel", rd1, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("arst_rd1_after", rd1, 32'h0);
        for (int i = 0; i < 31; i++) model[i] = 32'h0;
        sweepAll("post_rst");

        // The first write after reset release lands at the next rising edge.
        writeReg(5'd1, 32'hCAFEF00D);
        applyStimulus(5'd1, 5'd1, 5'd0, 1'b0);
        checkOutput("postrst_wr_rd1", rd1, 32'hCAFEF00D);
        checkOutput("postrst_wr_z", {31'h0, z}, 32'h0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
